// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ masters.
// One transaction is in flight at a time, and a watchdog aborts stalled transactions.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      timeout_err,
    output logic [ADDR_W-1:0]         address,
    output logic [DATA_W-1:0]         write_data,
    output logic                      read_request_valid,
    output logic                      write_request_valid,
    input  logic                      buffer_addr_valid,
    input  logic                      data_valid,
    input  logic                      write_done,
    input  logic [DATA_W-1:0]         read_data,
    output logic [1:0]                dbg_state
);

    // Handshake: a requester holds req_valid until it sees its one-cycle req_ready pulse.
    // The request fields are captured on that grant. Exactly one rsp_valid pulse follows later.
    // A request's memory-side valid is held until buffer_addr_valid is seen.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                timeout_err_q, timeout_err_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                rd_req_q, rd_req_d;
    logic                wr_req_q, wr_req_d;

    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    cand;
    logic                addr_ok;
    logic                rd_done;
    logic                wr_done;

    // First requester above the pointer, wrapping, wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign addr_ok = (state_q == ISSUE) && buffer_addr_valid;
    assign rd_done = !wr_q && data_valid && ((state_q == WAIT_RD) || addr_ok);
    assign wr_done = wr_q && write_done && ((state_q == WAIT_WR) || addr_ok);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        wr_d          = wr_q;
        wd_d          = wd_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        address_d     = address_q;
        write_data_d  = write_data_q;
        rd_req_d      = rd_req_q;
        wr_req_d      = wr_req_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    idx_d                = gnt_idx;
                    ptr_d                = gnt_idx;
                    wr_d                 = req_write[gnt_idx];
                    address_d            = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    write_data_d         = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                    req_ready_d[gnt_idx] = 1'b1;
                    rd_req_d             = !req_write[gnt_idx];
                    wr_req_d             = req_write[gnt_idx];
                    wd_d                 = '0;
                    state_d              = ISSUE;
                end
            end
            default: begin
                // Completion takes precedence over a watchdog expiry in the same cycle.
                if (rd_done || wr_done) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    if (rd_done) begin
                        rsp_data_d = read_data;
                    end
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    timeout_err_d      = 1'b1;
                    rd_req_d           = 1'b0;
                    wr_req_d           = 1'b0;
                    state_d            = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (addr_ok) begin
                        rd_req_d = 1'b0;
                        wr_req_d = 1'b0;
                        state_d  = wr_q ? WAIT_WR : WAIT_RD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            idx_q         <= '0;
            wr_q          <= 1'b0;
            wd_q          <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            address_q     <= '0;
            write_data_q  <= '0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            wr_q          <= wr_d;
            wd_q          <= wd_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            timeout_err_q <= timeout_err_d;
            address_q     <= address_d;
            write_data_q  <= write_data_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_data            = rsp_data_q;
    assign rsp_err             = rsp_err_q;
    assign timeout_err         = timeout_err_q;
    assign address             = address_q;
    assign write_data          = write_data_q;
    assign read_request_valid  = rd_req_q;
    assign write_request_valid = wr_req_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder, grant and response scoreboards,
// and hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 512;
    localparam int TMO = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WRD  = 2'd2;
    localparam logic [1:0] ST_WWR  = 2'd3;
    localparam logic [DW-1:0] IDLE_PAT = {16{32'hDEADBEEF}};

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic             timeout_err;
    logic [AW-1:0]    address;
    logic [DW-1:0]    write_data;
    logic             read_request_valid;
    logic             write_request_valid;
    logic             buffer_addr_valid;
    logic             data_valid;
    logic             write_done;
    logic [DW-1:0]    read_data;
    logic [1:0]       dbg_state;

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .timeout_err(timeout_err), .address(address), .write_data(write_data),
        .read_request_valid(read_request_valid), .write_request_valid(write_request_valid),
        .buffer_addr_valid(buffer_addr_valid), .data_valid(data_valid), .write_done(write_done),
        .read_data(read_data), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        logic [NR-1:0] rsp;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    gnt_t exp_gnt_q[$];
    rsp_t exp_rsp_q[$];

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    int done_cyc = 0;
    int run_len = 0;
    int last_run = 0;
    logic saw_wait_rd = 1'b0;

    logic          rq_write [NR];
    logic [AW-1:0] rq_addr  [NR];
    logic [DW-1:0] rq_wdata [NR];

    int            mem_bav_lat = 0;
    int            mem_done_lat = 2;
    logic          mem_same = 1'b0;
    logic          mem_never = 1'b0;
    logic          mem_fixed = 1'b0;
    logic [DW-1:0] mem_rdata_fixed = '0;
    logic          mem_busy = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
        return mem_fixed ? mem_rdata_fixed : {16{a}};
    endfunction

    task automatic push_gnt(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_t g;
        g.gnt = NR'(1) << idx;
        g.wr = wr;
        g.addr = a;
        g.wdata = d;
        exp_gnt_q.push_back(g);
    endtask

    task automatic push_rsp(input int idx, input logic [DW-1:0] d, input logic err);
        rsp_t r;
        r.rsp = NR'(1) << idx;
        r.data = d;
        r.err = err;
        exp_rsp_q.push_back(r);
    endtask

    task automatic set_rq(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_write[idx] = wr;
        rq_addr[idx]  = a;
        rq_wdata[idx] = d;
    endtask

    task automatic set_mem(input int bav, input int done, input logic same, input logic never);
        mem_bav_lat = bav;
        mem_done_lat = done;
        mem_same = same;
        mem_never = never;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, DW'(req_ready), '0);
        chk({tag, "_rsp_valid"}, DW'(rsp_valid), '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_rsp_err"}, DW'(rsp_err), '0);
        chk({tag, "_timeout_err"}, DW'(timeout_err), '0);
        chk({tag, "_address"}, DW'(address), '0);
        chk({tag, "_write_data"}, write_data, '0);
        chk({tag, "_rd_req"}, DW'(read_request_valid), '0);
        chk({tag, "_wr_req"}, DW'(write_request_valid), '0);
        chk({tag, "_state"}, DW'(dbg_state), DW'(ST_IDLE));
    endtask

    // ---------------- driver ----------------
    task automatic run_batch(input logic [NR-1:0] mask, input int n, output int lat);
        int got;
        int start;
        got = 0;
        lat = -1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_write[i] = rq_write[i];
            req_addr[i*AW +: AW] = rq_addr[i];
            req_wdata[i*DW +: DW] = rq_wdata[i];
        end
        req_valid = mask;
        start = cyc;
        for (int i = 0; i < 400 && got < n; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (got == 0) lat = cyc - start;
                got++;
                if (got == n) req_valid = '0;
            end
        end
        if (got < n) begin
            req_valid = '0;
            chk("grant_wait_expired", DW'(got), DW'(n));
        end
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && dbg_state == ST_IDLE && !mem_busy)
                ok = 1'b1;
        end
        if (!ok) chk({tag, "_idle_wait_expired"}, '0, DW'(1));
        repeat (2) @(negedge clk);
    endtask

    // ---------------- memory responder ----------------
    initial begin : mem_model
        logic          m_wr;
        logic [AW-1:0] m_addr;
        buffer_addr_valid = 1'b0;
        data_valid = 1'b0;
        write_done = 1'b0;
        read_data = IDLE_PAT;
        forever begin
            @(negedge clk);
            if (!rst && (read_request_valid || write_request_valid)) begin
                mem_busy = 1'b1;
                m_wr = write_request_valid;
                m_addr = address;
                repeat (mem_bav_lat) @(negedge clk);
                buffer_addr_valid = 1'b1;
                if (mem_same && !m_wr) begin
                    data_valid = 1'b1;
                    read_data = rdata_for(m_addr);
                    done_cyc = cyc;
                end
                @(negedge clk);
                buffer_addr_valid = 1'b0;
                data_valid = 1'b0;
                read_data = IDLE_PAT;
                if (!mem_same && !mem_never) begin
                    repeat (mem_done_lat - 1) @(negedge clk);
                    if (m_wr) begin
                        write_done = 1'b1;
                    end else begin
                        data_valid = 1'b1;
                        read_data = rdata_for(m_addr);
                    end
                    done_cyc = cyc;
                    @(negedge clk);
                    write_done = 1'b0;
                    data_valid = 1'b0;
                    read_data = IDLE_PAT;
                end
                mem_busy = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dbg_state == ST_WRD) saw_wait_rd = 1'b1;
                if (read_request_valid || write_request_valid) begin
                    run_len++;
                end else if (run_len != 0) begin
                    last_run = run_len;
                    run_len = 0;
                end
                if (req_ready != '0) begin
                    if (exp_gnt_q.size() == 0) begin
                        chk("unexpected_grant", DW'(req_ready), '0);
                    end else begin
                        g = exp_gnt_q.pop_front();
                        gnt_cyc = cyc;
                        chk("grant", DW'(req_ready), DW'(g.gnt));
                        chk("grant_addr", DW'(address), DW'(g.addr));
                        chk("grant_rd_req", DW'(read_request_valid), DW'(!g.wr));
                        chk("grant_wr_req", DW'(write_request_valid), DW'(g.wr));
                        if (g.wr) chk("grant_wdata", write_data, g.wdata);
                    end
                end
                if (rsp_valid != '0) begin
                    if (exp_rsp_q.size() == 0) begin
                        chk("unexpected_rsp", DW'(rsp_valid), '0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        chk("rsp_valid", DW'(rsp_valid), DW'(r.rsp));
                        chk("rsp_data", rsp_data, r.data);
                        chk("rsp_err", DW'(rsp_err), DW'(r.err));
                        if (r.err) chk("rsp_timeout_latency", DW'(cyc), DW'(gnt_cyc + TMO));
                        else       chk("rsp_latency", DW'(cyc), DW'(done_cyc + 1));
                    end
                end
            end
        end
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        int lat;
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) set_rq(i, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single read from requester 1
        mem_fixed = 1'b1;
        mem_rdata_fixed = {64{8'hA5}};
        set_mem(2, 5, 1'b0, 1'b0);
        set_rq(1, 1'b0, 32'h0000_1000, '0);
        push_gnt(1, 1'b0, 32'h0000_1000, '0);
        push_rsp(1, {64{8'hA5}}, 1'b0);
        run_batch(4'b0010, 1, lat);
        wait_idle("single_read");
        chk("read_grant_latency", DW'(lat), DW'(1));
        chk("read_req_cycles", DW'(last_run), DW'(3));
        mem_fixed = 1'b0;

        // Single write from requester 3
        set_mem(1, 2, 1'b0, 1'b0);
        set_rq(3, 1'b1, 32'h0002_0040, DW'(32'h1234));
        push_gnt(3, 1'b1, 32'h0002_0040, DW'(32'h1234));
        push_rsp(3, '0, 1'b0);
        run_batch(4'b1000, 1, lat);
        wait_idle("single_write");

        // All four continuously requesting: order 0,1,2,3,0,1
        set_mem(0, 3, 1'b0, 1'b0);
        set_rq(0, 1'b0, 32'h0000_0100, DW'(32'h1111));
        set_rq(1, 1'b1, 32'h0000_0200, DW'(32'h2222));
        set_rq(2, 1'b0, 32'h0000_0300, DW'(32'h3333));
        set_rq(3, 1'b1, 32'h0000_0400, DW'(32'h4444));
        push_gnt(0, 1'b0, 32'h0000_0100, DW'(32'h1111));
        push_gnt(1, 1'b1, 32'h0000_0200, DW'(32'h2222));
        push_gnt(2, 1'b0, 32'h0000_0300, DW'(32'h3333));
        push_gnt(3, 1'b1, 32'h0000_0400, DW'(32'h4444));
        push_gnt(0, 1'b0, 32'h0000_0100, DW'(32'h1111));
        push_gnt(1, 1'b1, 32'h0000_0200, DW'(32'h2222));
        push_rsp(0, {16{32'h0000_0100}}, 1'b0);
        push_rsp(1, '0, 1'b0);
        push_rsp(2, {16{32'h0000_0300}}, 1'b0);
        push_rsp(3, '0, 1'b0);
        push_rsp(0, {16{32'h0000_0100}}, 1'b0);
        push_rsp(1, '0, 1'b0);
        run_batch(4'b1111, 6, lat);
        wait_idle("round_robin");

        // Address accept and read data in the same cycle
        set_mem(1, 2, 1'b1, 1'b0);
        set_rq(2, 1'b0, 32'h0000_2000, '0);
        push_gnt(2, 1'b0, 32'h0000_2000, '0);
        push_rsp(2, {16{32'h0000_2000}}, 1'b0);
        saw_wait_rd = 1'b0;
        run_batch(4'b0100, 1, lat);
        wait_idle("same_cycle");
        chk("same_cycle_no_wait_rd", DW'(saw_wait_rd), '0);
        chk("same_cycle_back_idle", DW'(dbg_state), DW'(ST_IDLE));

        // Completion on the last watchdog cycle wins over timeout
        set_mem(0, TMO - 1, 1'b0, 1'b0);
        set_rq(3, 1'b0, 32'h0000_3000, '0);
        push_gnt(3, 1'b0, 32'h0000_3000, '0);
        push_rsp(3, {16{32'h0000_3000}}, 1'b0);
        run_batch(4'b1000, 1, lat);
        wait_idle("coincide");
        chk("coincide_no_sticky", DW'(timeout_err), '0);

        // Memory never returns data
        set_mem(1, 2, 1'b0, 1'b1);
        set_rq(0, 1'b0, 32'h0000_4000, '0);
        push_gnt(0, 1'b0, 32'h0000_4000, '0);
        push_rsp(0, '0, 1'b1);
        run_batch(4'b0001, 1, lat);
        wait_idle("timeout");
        chk("timeout_sticky", DW'(timeout_err), DW'(1));

        // Normal service after a timeout
        set_mem(1, 2, 1'b0, 1'b0);
        set_rq(1, 1'b0, 32'h0000_5000, '0);
        push_gnt(1, 1'b0, 32'h0000_5000, '0);
        push_rsp(1, {16{32'h0000_5000}}, 1'b0);
        run_batch(4'b0010, 1, lat);
        wait_idle("after_timeout");
        chk("timeout_still_sticky", DW'(timeout_err), DW'(1));

        // Reset while waiting for write completion
        set_mem(0, 10, 1'b0, 1'b0);
        set_rq(2, 1'b1, 32'h0000_6000, DW'(32'hBEEF));
        push_gnt(2, 1'b1, 32'h0000_6000, DW'(32'hBEEF));
        run_batch(4'b0100, 1, lat);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (dbg_state == ST_WWR) seen = 1'b1;
                else @(negedge clk);
            end
            chk("reached_wait_wr", DW'(seen), DW'(1));
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_idle("post_reset");

        // Pointer restored by reset: requester 0 before 3
        set_mem(0, 2, 1'b0, 1'b0);
        set_rq(0, 1'b0, 32'h0000_7000, '0);
        set_rq(3, 1'b0, 32'h0000_7300, '0);
        push_gnt(0, 1'b0, 32'h0000_7000, '0);
        push_gnt(3, 1'b0, 32'h0000_7300, '0);
        push_rsp(0, {16{32'h0000_7000}}, 1'b0);
        push_rsp(3, {16{32'h0000_7300}}, 1'b0);
        run_batch(4'b1001, 2, lat);
        wait_idle("after_reset_rr");

        chk("grant_queue_drained", DW'(exp_gnt_q.size()), '0);
        chk("rsp_queue_drained", DW'(exp_rsp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
